// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back stage.
package wb_pkg;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_MSB = 6;
  localparam int unsigned F3_LSB  = 7;
  localparam int unsigned F3_MSB  = 9;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load alignment: selects byte/half/word at the offset and extends it.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] off,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic [XLEN-1:0]  data_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  // Half and word lanes ignore the offset bits below their own size.
  always_comb begin
    byte_v = 8'(mem_rdata >> {off, 3'b000});
    half_v = 16'(mem_rdata >> {off & ~OFF_W'(1), 3'b000});
    word_v = 32'(mem_rdata >> {off & ~OFF_W'(3), 3'b000});
  end

  always_comb begin
    data_c = mem_rdata;
    case (funct3)
      F3_LB:   data_c = XLEN'($signed(byte_v));
      F3_LBU:  data_c = XLEN'(byte_v);
      F3_LH:   data_c = XLEN'($signed(half_v));
      F3_LHU:  data_c = XLEN'(half_v);
      F3_LW:   data_c = XLEN'($signed(word_v));
      F3_LWU:  data_c = (XLEN == 64) ? XLEN'(word_v) : mem_rdata;
      F3_LD:   data_c = mem_rdata;
      default: data_c = mem_rdata;
    endcase
  end

endmodule

// File: rtl/write_back.sv
// Write-back stage: registers non-load results to the RF, runs loads through data memory.
// Optional memory-wait timeout enabled with `define WB_TIMEOUT_EN.
module write_back
  import wb_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned RA_W           = 5,
  parameter int unsigned CODE_W         = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              write_enabled,
  input  logic [CODE_W-1:0] code,
  input  logic [RA_W-1:0]   rd,
  input  logic [XLEN-1:0]   data_alu,
  input  logic [XLEN-1:0]   mem_address,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_addr,
  output logic [XLEN-1:0]   rf_data,
  output logic              busy,
  output logic              err
);

  localparam int unsigned   OFF_W    = $clog2(XLEN / 8);
  localparam logic [XLEN-1:0] OFF_MASK = XLEN'(XLEN / 8 - 1);

  wb_state_e        state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic             busy_q, busy_d;
  logic             rf_we_q, rf_we_d;
  logic [RA_W-1:0]  rf_addr_q, rf_addr_d;
  logic [XLEN-1:0]  rf_data_q, rf_data_d;
  logic [RA_W-1:0]  rd_q, rd_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [XLEN-1:0]  aligned_c;
  logic             xfer_c;
  logic             is_load_c;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             unused_ok;
  assign unused_ok = &{1'b0, code[CODE_W-1:F3_MSB+1]};
  assign err       = err_q;
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, code[CODE_W-1:F3_MSB+1], 32'(TIMEOUT_CYCLES)};
  assign err       = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE) && !rst;
  assign xfer_c    = in_valid && in_ready;
  assign is_load_c = (code[OPC_MSB:OPC_LSB] == OPC_LOAD);

  wb_load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
    .funct3    (f3_q),
    .off       (off_q),
    .mem_rdata (mem_rdata),
    .data_c    (aligned_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    busy_d     = busy_q;
    rf_we_d    = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    rd_d       = rd_q;
    we_d       = we_q;
    f3_d       = f3_q;
    off_d      = off_q;
`ifdef WB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (xfer_c) begin
          if (is_load_c) begin
            rd_d       = rd;
            we_d       = write_enabled;
            f3_d       = code[F3_MSB:F3_LSB];
            off_d      = mem_address[OFF_W-1:0];
            mem_req_d  = 1'b1;
            mem_addr_d = mem_address & ~OFF_MASK;
            busy_d     = 1'b1;
            state_d    = WAIT;
`ifdef WB_TIMEOUT_EN
            cnt_d      = '0;
`endif
          end else begin
            rf_we_d   = write_enabled && (rd != '0);
            rf_addr_d = rd;
            rf_data_d = data_alu;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
          rf_we_d   = we_q && (rd_q != '0);
          rf_addr_d = rd_q;
          rf_data_d = aligned_c;
        end
`ifdef WB_TIMEOUT_EN
        // An ack on the limit cycle takes the branch above and wins.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
`ifdef WB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
`ifdef WB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_data  = rf_data_q;

endmodule

// File: tb/tb_write_back.sv
// Directed self-checking bench for write_back (XLEN=32).
module tb_write_back;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic            write_enabled;
  logic [11:0]     code;
  logic [4:0]      rd;
  logic [XLEN-1:0] data_alu;
  logic [XLEN-1:0] mem_address;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            rf_we;
  logic [4:0]      rf_addr;
  logic [XLEN-1:0] rf_data;
  logic            busy;
  logic            err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  write_back #(
    .XLEN(XLEN)
`ifdef WB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .write_enabled(write_enabled), .code(code), .rd(rd), .data_alu(data_alu),
    .mem_address(mem_address), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_data(rf_data), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] r,
                       input logic we, input logic [31:0] alu, input logic [31:0] addr);
    in_valid      = 1'b1;
    code          = {2'b00, f3, opc};
    rd            = r;
    write_enabled = we;
    data_alu      = alu;
    mem_address   = addr;
  endtask

  // Issue one load, ack after lat idle wait cycles, check the write-back.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input int lat, input logic exp_we, input logic [31:0] exp_data);
    offer(7'b0000011, f3, r, 1'b1, 32'h0, addr);
    step();
    in_valid = 1'b0;
    chk({tag, "_req"}, 64'(mem_req), 64'(1));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(addr & 32'hFFFF_FFFC));
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    chk({tag, "_rdy"}, 64'(in_ready), 64'(0));
    for (int i = 0; i < lat; i++) begin
      step();
      chk({tag, "_wait_we"}, 64'(rf_we), 64'(0));
      chk({tag, "_wait_req"}, 64'(mem_req), 64'(1));
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    step();
    mem_ack   = 1'b0;
    chk({tag, "_we"}, 64'(rf_we), 64'(exp_we));
    if (exp_we) begin
      chk({tag, "_rfaddr"}, 64'(rf_addr), 64'(r));
      chk({tag, "_data"}, 64'(rf_data), 64'(exp_data));
    end
    chk({tag, "_req_off"}, 64'(mem_req), 64'(0));
    chk({tag, "_busy_off"}, 64'(busy), 64'(0));
    chk({tag, "_rdy_on"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; write_enabled = 1'b0; code = '0; rd = '0;
    data_alu = '0; mem_address = '0; mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_ready", 64'(in_ready), 64'(0));
    chk("rst_we", 64'(rf_we), 64'(0));
    chk("rst_req", 64'(mem_req), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_rfdata", 64'(rf_data), 64'(0));
    chk("rst_memaddr", 64'(mem_addr), 64'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(in_ready), 64'(1));

    // Back-to-back non-load bundles, reserved code bits set on the second.
    offer(7'h33, 3'b000, 5'd5, 1'b1, 32'hDEADBEEF, 32'h0);
    step();
    chk("pt_we", 64'(rf_we), 64'(1));
    chk("pt_addr", 64'(rf_addr), 64'(5));
    chk("pt_data", 64'(rf_data), 64'hDEADBEEF);
    offer(7'h13, 3'b000, 5'd6, 1'b1, 32'h12345678, 32'h0);
    code[11:10] = 2'b11;
    step();
    chk("b2b_we", 64'(rf_we), 64'(1));
    chk("b2b_addr", 64'(rf_addr), 64'(6));
    chk("b2b_data", 64'(rf_data), 64'h12345678);
    offer(7'h33, 3'b000, 5'd0, 1'b1, 32'hCAFEF00D, 32'h0);
    step();
    chk("rd0_we", 64'(rf_we), 64'(0));
    offer(7'h33, 3'b000, 5'd7, 1'b0, 32'h1, 32'h0);
    step();
    chk("wen0_we", 64'(rf_we), 64'(0));
    in_valid = 1'b0;
    mem_ack  = 1'b1;
    step();
    mem_ack  = 1'b0;
    chk("idle_ack_we", 64'(rf_we), 64'(0));
    chk("idle_ack_busy", 64'(busy), 64'(0));

    // Loads on rdata 0x80FF1234.
    do_load("lb", 3'b000, 5'd7, 32'h1003, 32'h80FF1234, 3, 1'b1, 32'hFFFFFF80);
    // A bundle is accepted in the write-back cycle of the load.
    offer(7'h33, 3'b000, 5'd9, 1'b1, 32'h99, 32'h0);
    step();
    in_valid = 1'b0;
    chk("after_load_we", 64'(rf_we), 64'(1));
    chk("after_load_data", 64'(rf_data), 64'h99);
    do_load("lbu", 3'b100, 5'd8, 32'h1003, 32'h80FF1234, 0, 1'b1, 32'h00000080);
    do_load("lh", 3'b001, 5'd10, 32'h1002, 32'h80FF1234, 1, 1'b1, 32'hFFFF80FF);
    do_load("lhu", 3'b101, 5'd11, 32'h1001, 32'h80FF1234, 2, 1'b1, 32'h00001234);
    do_load("lw", 3'b010, 5'd12, 32'h2002, 32'h80FF1234, 0, 1'b1, 32'h80FF1234);
    do_load("lb_pos", 3'b000, 5'd13, 32'h1001, 32'h80FF1234, 0, 1'b1, 32'h00000012);
    do_load("lrd0", 3'b000, 5'd0, 32'h1000, 32'h80FF1234, 1, 1'b0, 32'h0);

    // Bundle offered during WAIT must not be accepted.
    offer(7'b0000011, 3'b010, 5'd14, 1'b1, 32'h0, 32'h3000);
    step();
    offer(7'h33, 3'b000, 5'd15, 1'b1, 32'h55, 32'h0);
    step();
    chk("wait_block_we", 64'(rf_we), 64'(0));
    chk("wait_block_req", 64'(mem_req), 64'(1));
    in_valid  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hA5A5_0001;
    step();
    mem_ack   = 1'b0;
    chk("wait_block_addr", 64'(rf_addr), 64'(14));
    chk("wait_block_data", 64'(rf_data), 64'hA5A50001);
    step();
    chk("wait_block_none", 64'(rf_we), 64'(0));

    // Reset in the middle of a pending load.
    offer(7'b0000011, 3'b000, 5'd16, 1'b1, 32'h0, 32'h4000);
    step();
    in_valid = 1'b0;
    chk("midrst_req_pre", 64'(mem_req), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_req", 64'(mem_req), 64'(0));
    chk("midrst_ready", 64'(in_ready), 64'(0));
    step();
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    chk("midrst_we", 64'(rf_we), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_ready_after", 64'(in_ready), 64'(1));

`ifdef WB_TIMEOUT_EN
    offer(7'b0000011, 3'b000, 5'd17, 1'b1, 32'h0, 32'h5000);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_err_early", 64'(err), 64'(0));
      chk("to_req_hold", 64'(mem_req), 64'(1));
    end
    step();
    chk("to_err", 64'(err), 64'(1));
    chk("to_req", 64'(mem_req), 64'(0));
    chk("to_busy", 64'(busy), 64'(0));
    chk("to_we", 64'(rf_we), 64'(0));
    offer(7'h33, 3'b000, 5'd3, 1'b1, 32'h33, 32'h0);
    step();
    in_valid = 1'b0;
    chk("to_err_pulse", 64'(err), 64'(0));
    chk("to_next_we", 64'(rf_we), 64'(1));
    chk("to_next_data", 64'(rf_data), 64'h33);
`else
    chk("no_to_err", 64'(err), 64'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Parametrised write-back stage of the core; sits between execute and the register file.
- Takes one instruction bundle per handshake from execute.
- Non-load results are registered straight to the register-file write port.
- Loads issue a word read to data memory, wait for the acknowledge, then align and sign/zero-extend the returned data before writing back.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- RA_W, 5, register address width.
- CODE_W, 12, instruction code width.
- TIMEOUT_CYCLES, 16, memory wait limit; used only with WB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  execute bundle valid.
- in_ready  out  1  stage can accept a bundle.
- write_enabled  in  1  instruction writes rd.
- code  in  CODE_W  [6:0] opcode, [9:7] funct3, [11:10] reserved.
- rd  in  RA_W  destination register.
- data_alu  in  XLEN  execute result.
- mem_address  in  XLEN  load byte address.
- mem_req  out  1  memory read request.
- mem_addr  out  XLEN  address aligned down to an XLEN/8-byte word.
- mem_ack  in  1  read data valid.
- mem_rdata  in  XLEN  read data.
- rf_we  out  1  register-file write strobe, one-cycle pulse.
- rf_addr  out  RA_W  write address.
- rf_data  out  XLEN  write data.
- busy  out  1  load outstanding.
- err  out  1  timeout pulse; tied 0 without WB_TIMEOUT_EN.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - rf_we, rf_addr, rf_data, mem_req, mem_addr, busy and err are all 0.
  - in_ready is 0 while rst=1.
- Reset mid-WAIT: mem_req drops immediately and the pending load is discarded; no write-back.
- Two states, IDLE and WAIT. in_ready = (state==IDLE) && !rst.
- A transfer happens when in_valid && in_ready.
- Non-load transfer at edge T:
  - Output at T+1: rf_we = write_enabled && rd!=0, rf_addr=rd, rf_data=data_alu.
  - Latency 1; throughput 1 per cycle.
- Load transfer (opcode 7'b0000011) at edge T:
  - Captures rd, write_enabled, funct3 and the byte offset off = mem_address[log2(XLEN/8)-1:0].
  - At T+1: mem_req=1, mem_addr = mem_address with the offset bits cleared, busy=1, state WAIT.
  - rf_we=0 from T+1 while waiting.
- WAIT:
  - mem_req and mem_addr are held until a cycle with mem_ack=1; mem_ack is valid from the first mem_req cycle.
  - On the ack edge: mem_req=0, busy=0, state IDLE, and the aligned data is written with rf_we = captured we && rd!=0, one cycle after ack.
  - No new bundle is accepted in WAIT. A bundle can be accepted in the cycle the load writes back.
  - mem_ack while IDLE is ignored.
- Alignment (funct3):
  - 000 LB: byte at off, sign-extended.
  - 100 LBU: byte at off, zero-extended.
  - 001 LH: halfword at off with bit 0 ignored, sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: word at off[XLEN==64 ? 2 : n/a], sign-extended.
  - 110 LWU: same word, zero-extended.
  - 011 LD (XLEN=64): full doubleword.
  - Any funct3 not legal for XLEN returns the full mem_rdata.
- rd=0: the memory access still occurs; no write.
- Reserved code bits are ignored.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- With the macro defined:
  - A counter counts WAIT cycles.
  - If TIMEOUT_CYCLES cycles pass without mem_ack: mem_req and busy drop, err pulses 1 for one cycle, there is no write-back, and state returns to IDLE.
  - An ack in the same cycle as the limit wins.
- Without the macro: WAIT is unbounded and err is constant 0.

Decomposition:
- Package wb_pkg holds:
  - OPC_LOAD.
  - funct3 constants F3_LB..F3_LWU.
  - Code field positions.
  - The state enum {IDLE, WAIT}.
- Sub-module wb_load_align: combinational, taking (funct3, off, mem_rdata) and producing aligned XLEN data.

Test Plan:
- Reset and passthrough: reset, then non-load rd=5, data_alu=0xDEADBEEF, write_enabled=1 → one cycle later rf_we=1, rf_addr=5, rf_data=0xDEADBEEF. Back-to-back bundles give one write per cycle.
- rd=0 passthrough: rd=0, write_enabled=1 → rf_we stays 0.
- LB with ack latency: address 0x1003, mem_rdata=0x80FF_1234, ack 3 cycles after mem_req → mem_addr=0x1000, in_ready=0 during wait, rf_data=0xFFFFFF80 one cycle after ack.
- LBU / LH / LHU (same rdata):
  - LBU at 0x1003 → 0x00000080.
  - LH at 0x1002 → 0xFFFF80FF.
  - LHU at 0x1001 → 0x00001234.
- Reset mid-WAIT: assert rst while mem_req=1 → mem_req=0 the same cycle, no rf_we afterwards, in_ready=1 after release.
- Timeout (WB_TIMEOUT_EN, TIMEOUT_CYCLES=4): load with no ack → err pulses once after 4 wait cycles, no write, next bundle accepted.
